uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  UART transmitter with a 32-entry circular byte queue, the transmit
//  counterpart of the peripheral's receive path.
//  The bus side pushes bytes into the queue. The block serialises them
//  8N1, LSB first, on tx_o. The bit period is set by a runtime divider.
// PARAMETERS
//  (none) Queue depth is fixed at 32 entries (5-bit pointers); data width is 8.
// PORTS
//  clk_i       in   1   clock; all logic on posedge
//  rst_i       in   1   reset, synchronous, active-high
//  baud_div_i  in   16  bit period = baud_div_i+1 clk cycles
//  we_i        in   1   push data_i into queue (1 cycle = 1 byte)
//  data_i      in   8   byte to transmit
//  stall_i     in   1   1 = do not start a new frame (frame in flight completes)
//  full_o      out  1   queue full (31 bytes stored)
//  empty_o     out  1   queue empty
//  busy_o      out  1   frame in progress (state != IDLE)
//  tx_o        out  1   serial line, idles high
// BEHAVIOUR
//  Reset: read_ptr=write_ptr=0, state=IDLE, counter=0, tx_o=1, busy_o=0,
//   empty_o=1, full_o=0. Queue contents are not reset.
//  Reset mid-frame aborts the frame: tx_o=1 after the reset edge; queued bytes are discarded.
//  Queue flags (combinational from pointers):
//   empty_o = (read_ptr==write_ptr)
//   full_o  = (write_ptr+1 == read_ptr), 5-bit wrap, so 31 usable slots.
//  Push: if we_i && !full_o, then queue[write_ptr]<=data_i and write_ptr++.
//   we_i while full is dropped silently.
//  Pointers wrap 31->0 naturally.
//  A push and a pop in the same cycle are both performed; the flags use pre-edge pointers.
//  FSM states:
//   IDLE -> START -> D0..D7 -> [PARITY] -> STOP -> IDLE
//  IDLE, at each edge: if !empty_o && !stall_i, then
//   - shreg<=queue[read_ptr], read_ptr++
//   - div_r<=baud_div_i, counter<=0
//   - state<=START
//  Otherwise the FSM stays in IDLE.
//  Each non-IDLE state holds for div_r+1 cycles. When counter==div_r, the
//   counter clears and the FSM advances; otherwise counter++.
//  div_r is latched at frame start, so a baud_div_i change takes effect on the next frame.
//  tx_o is registered and reflects the current state:
//   IDLE=1, START=0, Dn=shreg[n], PARITY=^shreg, STOP=1.
//  Latency: we_i sampled at edge N into an empty idle queue. START is entered at
//   edge N+1; tx_o=0 is visible after edge N+1.
//  Back-to-back frames: STOP->IDLE, then one IDLE cycle (tx_o=1) before the next START.
//   The gap is 1 clk beyond the stop bit.
//  stall_i is sampled only in IDLE and never truncates a frame.
//  baud_div_i=0 is legal: 1 clk per bit.
// CONFIGURATION
//  `UART_TX_PARITY_EN defined:
//   - PARITY state inserted between D7 and STOP, driving the even-parity bit (^shreg).
//   - Frame is 11 bits (8E1).
//  Undefined: no PARITY state, D7->STOP, frame is 10 bits (8N1).
// TESTING
//  1. Reset, then idle 20 cycles -> tx_o=1, empty_o=1, full_o=0, busy_o=0 throughout.
//  2. baud_div_i=3, push 0xA5 -> tx_o sequence, 4 clk each:
//     0, 1,0,1,0,0,1,0,1, 1. Frame is 40 clk; busy_o falls after STOP.
//  3. stall_i=1 with div=0: push 31 bytes -> full_o=1.
//     Push 0x77 -> dropped.
//     Release stall -> exactly 31 frames, in order; empty_o=1 at end.
//  4. Push 0x01,0x02 back-to-back with div=1 -> two frames separated by one extra idle
//     clk. Pointer wrap is exercised by repeating until write_ptr passes 31->0.
//  5. Reset asserted at D3 of a frame -> tx_o=1 next cycle, empty_o=1,
//     no further frames.
//  6. `UART_TX_PARITY_EN, div=3, push 0xA5 then 0x07 -> parity bits 0 then 1;
//     frames are 44 clk each.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 32-entry circular byte queue feeding an 8N1 serialiser,
// LSB first, with a runtime bit-period divider latched at frame start.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        we_i,
  input  logic [7:0]  data_i,
  input  logic        stall_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        busy_o,
  output logic        tx_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state, state_n;
  logic [7:0]  mem [32];
  logic [4:0]  rd_ptr, wr_ptr;
  logic [15:0] div_r, div_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        pop, push, tx_n;

  // Flags come straight from the pointers; one slot stays unused to tell full from empty.
  assign empty_o = (rd_ptr == wr_ptr);
  assign full_o  = ((wr_ptr + 5'd1) == rd_ptr);
  assign busy_o  = (state != S_IDLE);
  assign push    = we_i && !full_o;

  // Queue storage, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Next-state logic: frame start from IDLE, per-bit timing, and the line level.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    div_n   = div_r;
    shreg_n = shreg;
    pop     = 1'b0;
    tx_n    = 1'b1;
    if (state == S_IDLE) begin
      if (!empty_o && !stall_i) begin
        pop     = 1'b1;
        shreg_n = mem[rd_ptr];
        div_n   = baud_div_i;
        cnt_n   = '0;
        bit_n   = '0;
        state_n = S_START;
      end
    end else if (cnt == div_r) begin
      cnt_n = '0;
      case (state)
        S_START: begin
          state_n = S_DATA;
          bit_n   = '0;
        end
        S_DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
        S_PARITY: state_n = S_STOP;
        default:  state_n = S_IDLE;
      endcase
    end else begin
      cnt_n = cnt + 16'd1;
    end
    // Line level is registered from the state being entered.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[bit_n];
      S_PARITY: tx_n = ^shreg_n;
      default:  tx_n = 1'b1;
    endcase
  end

  // State, pointers and line register; reset aborts any frame and empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      div_r   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      rd_ptr  <= rd_ptr + {4'd0, pop};
      wr_ptr  <= wr_ptr + {4'd0, push};
      cnt     <= cnt_n;
      div_r   <= div_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_o    <= tx_n;
    end
  end

endmodule
